// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one operand bit per clock, WIDTH steps per product.
// Define SEQ_MULT_SIGNED_EN to treat a, b and p as two's-complement signed values.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_next;
    logic [PW-1:0]   a_ext;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic            last_step;

    assign last_step = (cnt == CW'(WIDTH - 1));
    assign busy      = (state == RUN);
    assign addend    = mplier[0] ? mcand : '0;

`ifdef SEQ_MULT_SIGNED_EN
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    // The multiplier's sign bit carries weight -2^(WIDTH-1), so the final step subtracts.
    assign acc_next = last_step ? (acc - addend) : (acc + addend);
`else
    assign a_ext    = {{WIDTH{1'b0}}, a};
    assign acc_next = acc + addend;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p      <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_ext;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    // p only moves on completion, so it holds through the next run.
                    if (last_step) begin
                        p    <= acc_next;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
